sb_handshake_ctrl: RTL and testbench

SB_HANDSHAKE_CTRL -- requirements
Module: sb_handshake_ctrl

---
 rtl/sb_handshake_pkg.sv | 18 +
 rtl/sb_handshake_ctrl_timeout.sv | 41 ++++
 rtl/sb_handshake_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sb_handshake_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sb_handshake_pkg.sv
// Shared definitions for the sideband handshake controller:
// FSM state encodings and default sideband message codes.
package sb_handshake_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        TX_REQ  = 3'd2,
        TX_RESP = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } sb_state_e;

    localparam int unsigned SB_MSG_W_DEF    = 4;
    localparam logic [3:0]  SB_REQ_MSG_DEF  = 4'b0001;
    localparam logic [3:0]  SB_RESP_MSG_DEF = 4'b0010;

endpackage

// File: rtl/sb_handshake_ctrl_timeout.sv
// sb_timeout_cnt: handshake watchdog counter.
// Ports: clk_i, rst_ni (async, active-low), clr_i (clear),
//        inc_i (count this cycle), expired_o (count == TIMEOUT_CYCLES-1).
module sb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] Max  = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Saturate so a stalled count never wraps back below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == Last);

endmodule

// File: rtl/sb_handshake_ctrl.sv
// sb_handshake_ctrl: sideband REQ/RESP handshake FSM with optional timeout.
// Ports: CLK, rst_n, i_en, i_Busy_SideBand, i_falling_edge_busy,
//        i_RX_SbMessage/i_msg_valid (RX), o_TX_SbMessage/
//        o_ValidOutDatat_Module (TX), o_end, o_timeout.
// Build option: define SB_TIMEOUT_EN to enable the timeout watchdog.
module sb_handshake_ctrl
    import sb_handshake_pkg::*;
#(
    parameter int unsigned SB_MSG_WIDTH   = SB_MSG_W_DEF,
    parameter logic [SB_MSG_WIDTH-1:0] REQ_MSG =
        SB_MSG_WIDTH'(SB_REQ_MSG_DEF),
    parameter logic [SB_MSG_WIDTH-1:0] RESP_MSG =
        SB_MSG_WIDTH'(SB_RESP_MSG_DEF),
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_Busy_SideBand,
    input  logic                    i_falling_edge_busy,
    input  logic [SB_MSG_WIDTH-1:0] i_RX_SbMessage,
    input  logic                    i_msg_valid,
    output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
    output logic                    o_ValidOutDatat_Module,
    output logic                    o_end,
    output logic                    o_timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    sb_state_e state_q, state_d;
    logic req_done_q, req_done_d;
    logic resp_done_q, resp_done_d;
    logic resp_rcvd_q, resp_rcvd_d;
    logic pend_resp_q, pend_resp_d;
    logic [SB_MSG_WIDTH-1:0] tx_msg_q;
    logic valid_q;
    logic end_q;
    logic timeout_hit;
    logic rx_req;
    logic rx_resp;

    assign rx_req  = i_msg_valid && (i_RX_SbMessage == REQ_MSG);
    assign rx_resp = i_msg_valid && (i_RX_SbMessage == RESP_MSG);

`ifdef SB_TIMEOUT_EN
    logic active;
    logic expired;
    logic timeout_q;

    assign active = (state_q == ARB) || (state_q == TX_REQ) ||
                    (state_q == TX_RESP);

    sb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (CLK),
        .rst_ni   (rst_n),
        .clr_i    (state_q == IDLE),
        .inc_i    (active),
        .expired_o(expired)
    );

    assign timeout_hit = active && expired;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_d == ERROR);
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    // Disable wins over everything so an abort always returns to a
    // clean IDLE; otherwise the watchdog overrides normal flow.
    always_comb begin
        state_d     = state_q;
        req_done_d  = req_done_q;
        resp_done_d = resp_done_q;
        resp_rcvd_d = resp_rcvd_q;
        pend_resp_d = pend_resp_q;
        if (!i_en) begin
            state_d     = IDLE;
            req_done_d  = 1'b0;
            resp_done_d = 1'b0;
            resp_rcvd_d = 1'b0;
            pend_resp_d = 1'b0;
        end else begin
            if (state_q != IDLE) begin
                if (rx_req && !resp_done_q) begin
                    pend_resp_d = 1'b1;
                end
                if (rx_resp) begin
                    resp_rcvd_d = 1'b1;
                end
            end
            if (timeout_hit) begin
                state_d = ERROR;
            end else begin
                unique case (state_q)
                    IDLE: state_d = ARB;
                    ARB: begin
                        if (pend_resp_q && !i_Busy_SideBand) begin
                            state_d = TX_RESP;
                        end else if (!req_done_q && !i_Busy_SideBand) begin
                            state_d = TX_REQ;
                        end else if (req_done_q && resp_rcvd_q &&
                                     resp_done_q) begin
                            state_d = DONE;
                        end
                    end
                    TX_REQ: begin
                        if (i_falling_edge_busy) begin
                            state_d    = ARB;
                            req_done_d = 1'b1;
                        end
                    end
                    TX_RESP: begin
                        // Response sent: a REQ seen this cycle is the
                        // one just answered, so the clear wins.
                        if (i_falling_edge_busy) begin
                            state_d     = ARB;
                            resp_done_d = 1'b1;
                            pend_resp_d = 1'b0;
                        end
                    end
                    DONE:    state_d = DONE;
                    ERROR:   state_d = ERROR;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_done_q  <= 1'b0;
            resp_done_q <= 1'b0;
            resp_rcvd_q <= 1'b0;
            pend_resp_q <= 1'b0;
            valid_q     <= 1'b0;
            tx_msg_q    <= '0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_done_q  <= req_done_d;
            resp_done_q <= resp_done_d;
            resp_rcvd_q <= resp_rcvd_d;
            pend_resp_q <= pend_resp_d;
            valid_q     <= (state_d == TX_REQ) || (state_d == TX_RESP);
            tx_msg_q    <= (state_d == TX_REQ)  ? REQ_MSG  :
                           (state_d == TX_RESP) ? RESP_MSG : '0;
            end_q       <= (state_d == DONE);
        end
    end

    assign o_TX_SbMessage         = tx_msg_q;
    assign o_ValidOutDatat_Module = valid_q;
    assign o_end                  = end_q;

endmodule

// File: tb/tb_sb_handshake_ctrl.sv
// Directed self-checking bench for sb_handshake_ctrl.
// Expected outputs packed as {valid, tx_msg[3:0], end, timeout}.
module tb_sb_handshake_ctrl;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       i_en;
    logic       i_Busy_SideBand;
    logic       i_falling_edge_busy;
    logic [3:0] i_RX_SbMessage;
    logic       i_msg_valid;
    logic [3:0] o_TX_SbMessage;
    logic       o_ValidOutDatat_Module;
    logic       o_end;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] Z   = 7'b0_0000_0_0;
    localparam logic [6:0] RQ  = 7'b1_0001_0_0;
    localparam logic [6:0] RS  = 7'b1_0010_0_0;
    localparam logic [6:0] EN  = 7'b0_0000_1_0;
    localparam logic [6:0] TO  = 7'b0_0000_0_1;

    sb_handshake_ctrl #(
        .SB_MSG_WIDTH  (4),
        .REQ_MSG       (4'b0001),
        .RESP_MSG      (4'b0010),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK                   (CLK),
        .rst_n                 (rst_n),
        .i_en                  (i_en),
        .i_Busy_SideBand       (i_Busy_SideBand),
        .i_falling_edge_busy   (i_falling_edge_busy),
        .i_RX_SbMessage        (i_RX_SbMessage),
        .i_msg_valid           (i_msg_valid),
        .o_TX_SbMessage        (o_TX_SbMessage),
        .o_ValidOutDatat_Module(o_ValidOutDatat_Module),
        .o_end                 (o_end),
        .o_timeout             (o_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       en;
        logic       busy;
        logic       fall;
        logic       mv;
        logic [3:0] rx;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic en, input logic busy,
                                input logic fall, input logic mv,
                                input logic [3:0] rx,
                                input logic [6:0] exp);
        vec_t v;
        v.en = en; v.busy = busy; v.fall = fall;
        v.mv = mv; v.rx = rx; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {o_ValidOutDatat_Module, o_TX_SbMessage, o_end, o_timeout};
    endfunction

    task automatic chk(input string nm, input logic [6:0] exp);
        logic [6:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic busy,
                         input logic fall, input logic mv,
                         input logic [3:0] rx);
        i_en = en;
        i_Busy_SideBand = busy;
        i_falling_edge_busy = fall;
        i_msg_valid = mv;
        i_RX_SbMessage = rx;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Normal handshake: REQ out, partner REQ then RESP, RESP out, end.
        tbl[0]  = mk(1, 0, 0, 0, 4'h0, Z);
        tbl[1]  = mk(1, 0, 0, 0, 4'h0, RQ);
        tbl[2]  = mk(1, 1, 0, 0, 4'h0, RQ);
        tbl[3]  = mk(1, 0, 1, 0, 4'h0, Z);
        tbl[4]  = mk(1, 0, 0, 1, 4'h7, Z);
        tbl[5]  = mk(1, 0, 0, 0, 4'h1, Z);
        tbl[6]  = mk(1, 0, 0, 1, 4'h1, Z);
        tbl[7]  = mk(1, 0, 0, 0, 4'h0, RS);
        tbl[8]  = mk(1, 0, 0, 1, 4'h2, RS);
        tbl[9]  = mk(1, 0, 1, 0, 4'h0, Z);
        tbl[10] = mk(1, 0, 0, 0, 4'h0, EN);
        tbl[11] = mk(1, 0, 0, 1, 4'h1, EN);
        tbl[12] = mk(0, 0, 0, 0, 4'h0, Z);
        // Partner REQ while busy in ARB: RESP goes out first.
        tbl[13] = mk(1, 1, 0, 0, 4'h0, Z);
        tbl[14] = mk(1, 1, 0, 1, 4'h1, Z);
        tbl[15] = mk(1, 0, 0, 0, 4'h0, RS);
        tbl[16] = mk(1, 0, 1, 0, 4'h0, Z);
        tbl[17] = mk(1, 0, 0, 0, 4'h0, RQ);
        tbl[18] = mk(1, 0, 1, 0, 4'h0, Z);
        tbl[19] = mk(1, 0, 0, 0, 4'h0, Z);
        tbl[20] = mk(1, 0, 0, 1, 4'h2, Z);
        tbl[21] = mk(1, 0, 0, 0, 4'h0, EN);
        tbl[22] = mk(0, 0, 0, 0, 4'h0, Z);
        // RX event coinciding with the falling-edge pulse.
        tbl[23] = mk(1, 0, 0, 0, 4'h0, Z);
        tbl[24] = mk(1, 0, 0, 0, 4'h0, RQ);
        tbl[25] = mk(1, 0, 1, 1, 4'h1, Z);
        tbl[26] = mk(1, 0, 0, 1, 4'h2, RS);
        tbl[27] = mk(1, 0, 1, 0, 4'h0, Z);
        tbl[28] = mk(1, 0, 0, 0, 4'h0, EN);
        tbl[29] = mk(0, 0, 0, 0, 4'h0, Z);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 4'h0);
        #12;
        chk("reset", Z);
        @(negedge CLK);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", Z);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].en, tbl[i].busy, tbl[i].fall,
                  tbl[i].mv, tbl[i].rx);
            step();
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Busy blocking, then abort during TX_REQ and restart.
        drive(1, 1, 0, 0, 4'h0);
        step();
        chk("busy_arb", Z);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("busy_hold%0d", i), Z);
        end
        drive(1, 0, 0, 0, 4'h0);
        chk("busy_fell_pre_edge", Z);
        step();
        chk("busy_release_req", RQ);
        drive(0, 0, 0, 0, 4'h0);
        step();
        chk("abort", Z);
        drive(1, 0, 0, 0, 4'h0);
        step();
        chk("restart_arb", Z);
        step();
        chk("restart_req", RQ);
        drive(0, 0, 0, 0, 4'h0);
        step();
        chk("restart_off", Z);

        // No RESP ever arrives: watchdog after 16 active cycles.
        drive(1, 0, 0, 0, 4'h0);
        step();
        step();
        chk("to_req", RQ);
        drive(1, 0, 1, 0, 4'h0);
        step();
        drive(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 13; i++) begin
            step();
        end
        chk("to_edge16", Z);
        step();
`ifdef SB_TIMEOUT_EN
        chk("to_edge17", TO);
        step();
        chk("to_held", TO);
`else
        chk("to_edge17", Z);
        step();
        chk("to_held", Z);
`endif
        drive(0, 0, 0, 0, 4'h0);
        step();
        chk("to_clear", Z);

        // Asynchronous reset mid-handshake.
        drive(1, 0, 0, 0, 4'h0);
        step();
        step();
        chk("rst_pre", RQ);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", Z);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_arb", Z);
        step();
        chk("rst_req", RQ);
        drive(0, 0, 0, 0, 4'h0);
        step();
        chk("rst_off", Z);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
